// File: rtl/pad_od_ctrl.sv
// Core-side controller for one bidirectional pad: OEN/I/PEN generation in open-drain or
// push-pull mode, synchronized and glitch-filtered pad readback, sticky contention detect.
module pad_od_ctrl #(
   parameter int unsigned FILT_W   = 4,
   parameter int unsigned TURN_CYC = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              mode_pp_i,
   input  logic              drive_low_i,
   input  logic              pull_en_i,
   input  logic [FILT_W-1:0] filt_len_i,
   input  logic              clr_contention_i,
   output logic              pad_oen_o,
   output logic              pad_i_o,
   output logic              pad_pen_o,
   input  logic              pad_o_i,
   output logic              rx_o,
   output logic              rx_rise_o,
   output logic              rx_fall_o,
   output logic              contention_o
);

   localparam int unsigned CNT_W = (TURN_CYC > 2) ? $clog2(TURN_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_CYC - 1);

   typedef enum logic [1:0] {
      S_OFF,
      S_REL,
      S_SETTLE,
      S_CHK
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              oen_q, oen_d;
   logic              i_q, i_d;
   logic              pen_q, pen_d;
   logic              sync1_q, sync2_q;
   logic              rx_q, rx_d;
   logic [FILT_W-1:0] fcnt_q, fcnt_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              cont_q, cont_d;
   logic              drv, val;

   // Open-drain only ever drives 0; push-pull always drives the requested level.
   assign drv = mode_pp_i | drive_low_i;
   assign val = mode_pp_i & ~drive_low_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      i_d     = i_q;
      case (state_q)
         S_OFF, S_REL: begin
            if (drv) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
               i_d     = val;
            end else begin
               state_d = S_REL;
            end
         end
         S_SETTLE: begin
            if (!drv) begin
               state_d = S_REL;
            end else if (val != i_q) begin
               cnt_d = '0;
               i_d   = val;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_CHK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CHK: begin
            if (!drv) begin
               state_d = S_REL;
            end else if (val != i_q) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
               i_d     = val;
            end
         end
         default: state_d = S_OFF;
      endcase
      if (!en_i) begin
         state_d = S_OFF;
         cnt_d   = '0;
         i_d     = i_q;
      end
      oen_d = !((state_d == S_SETTLE) || (state_d == S_CHK));
      pen_d = ~(en_i & pull_en_i);
   end

   // Contention is evaluated on every edge spent in CHK, even one that leaves it.
   always_comb begin
      cont_d = ((state_q == S_CHK) && (sync2_q != i_q)) | (cont_q & ~clr_contention_i);
   end

   always_comb begin
      rx_d   = rx_q;
      fcnt_d = fcnt_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync2_q == rx_q) begin
         fcnt_d = '0;
      end else if (fcnt_q >= filt_len_i) begin
         rx_d   = sync2_q;
         fcnt_d = '0;
         rise_d = sync2_q;
         fall_d = ~sync2_q;
      end else if (fcnt_q != '1) begin
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         oen_q   <= 1'b1;
         i_q     <= 1'b0;
         pen_q   <= 1'b1;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         rx_q    <= 1'b1;
         fcnt_q  <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cont_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         oen_q   <= oen_d;
         i_q     <= i_d;
         pen_q   <= pen_d;
         sync1_q <= pad_o_i;
         sync2_q <= sync1_q;
         rx_q    <= rx_d;
         fcnt_q  <= fcnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cont_q  <= cont_d;
      end
   end

   assign pad_oen_o    = oen_q;
   assign pad_i_o      = i_q;
   assign pad_pen_o    = pen_q;
   assign rx_o         = rx_q;
   assign rx_rise_o    = rise_q;
   assign rx_fall_o    = fall_q;
   assign contention_o = cont_q;

endmodule

// File: tb/tb_pad_od_ctrl.sv
// Directed and randomized bench for pad_od_ctrl against a behavioural drive/filter model.
module tb_pad_od_ctrl;

   localparam int FILT_W   = 4;
   localparam int TURN_CYC = 3;

   logic              clk = 1'b0;
   logic              rst, en, mode_pp, drive_low, pull_en, clr, pad_o;
   logic [FILT_W-1:0] filt_len;
   logic              pad_oen, pad_i, pad_pen, rx, rx_rise, rx_fall, contention;

   int errors = 0;
   int checks = 0;

   // model state: drive established / driven value / edges since value established
   bit m_drive, m_val, m_s1, m_s2, m_rx, m_rise, m_fall, m_cont, m_pen;
   int m_age, m_run;
   bit ext_low, ext_high;

   always #5 clk = ~clk;

   pad_od_ctrl #(.FILT_W(FILT_W), .TURN_CYC(TURN_CYC)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .mode_pp_i(mode_pp), .drive_low_i(drive_low),
      .pull_en_i(pull_en), .filt_len_i(filt_len), .clr_contention_i(clr),
      .pad_oen_o(pad_oen), .pad_i_o(pad_i), .pad_pen_o(pad_pen), .pad_o_i(pad_o),
      .rx_o(rx), .rx_rise_o(rx_rise), .rx_fall_o(rx_fall), .contention_o(contention)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural view of one clock edge, using the inputs held during the preceding cycle.
   task automatic model_edge();
      bit drv, val, hit;
      drv = mode_pp ? 1'b1 : drive_low;
      val = mode_pp ? ~drive_low : 1'b0;
      if (rst) begin
         m_drive = 0; m_val = 0; m_age = 0; m_s1 = 1; m_s2 = 1; m_rx = 1;
         m_run = 0; m_rise = 0; m_fall = 0; m_cont = 0; m_pen = 1;
         return;
      end
      hit    = m_drive && (m_age >= TURN_CYC) && (m_s2 != m_val);
      m_cont = hit | (m_cont & ~clr);
      m_rise = 0;
      m_fall = 0;
      if (m_s2 == m_rx) m_run = 0;
      else if (m_run >= int'(filt_len)) begin
         m_rx = m_s2; m_rise = m_s2; m_fall = ~m_s2; m_run = 0;
      end else m_run++;
      m_s2 = m_s1;
      m_s1 = pad_o;
      if (!en || !drv) m_drive = 0;
      else if (!m_drive || val != m_val) begin
         m_drive = 1; m_val = val; m_age = 0;
      end else if (m_age < TURN_CYC) m_age++;
      m_pen = ~(en & pull_en);
   endtask

   task automatic cycle();
      pad_o = ((m_drive ? m_val : 1'b1) & ~ext_low) | ext_high;
      @(posedge clk);
      model_edge();
      #1;
      chk("oen", pad_oen, ~m_drive);
      chk("pad_i", pad_i, m_val);
      chk("pen", pad_pen, m_pen);
      chk("rx", rx, m_rx);
      chk("rise", rx_rise, m_rise);
      chk("fall", rx_fall, m_fall);
      chk("contention", contention, m_cont);
   endtask

   task automatic do_reset();
      rst = 1;
      cycle();
      cycle();
      rst = 0;
   endtask

   initial begin
      int first, falls, hold;
      rst = 1; en = 1; mode_pp = 0; drive_low = 0; pull_en = 0; clr = 0;
      filt_len = '0; pad_o = 1; ext_low = 0; ext_high = 0;

      // reset with en held high
      do_reset();
      chk("rst_oen", pad_oen, 1'b1);
      chk("rst_i", pad_i, 1'b0);
      chk("rst_pen", pad_pen, 1'b1);
      chk("rst_rx", rx, 1'b1);
      chk("rst_cont", contention, 1'b0);

      // open-drain drive with loopback
      drive_low = 1;
      cycle();
      chk("od_oen_edge0", pad_oen, 1'b0);
      falls = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         if (rx_fall) falls++;
      end
      chk_int("od_fall_pulses", falls, 1);
      chk("od_no_cont", contention, 1'b0);

      // contention: pad held high while driving low
      do_reset();
      drive_low = 1; ext_high = 1;
      for (int e = 0; e <= 4; e++) begin
         cycle();
         chk("cont_timing", contention, (e == 4) ? 1'b1 : 1'b0);
      end
      drive_low = 0; ext_high = 0;
      cycle(); cycle(); cycle();
      clr = 1;
      cycle();
      clr = 0;
      chk("cont_clear", contention, 1'b0);

      // glitch filter, length 3: 3-cycle low pulse rejected
      do_reset();
      filt_len = 4'd3;
      falls = 0;
      for (int k = 0; k < 12; k++) begin
         ext_low = (k < 3);
         cycle();
         if (rx_fall) falls++;
      end
      chk_int("glitch3_falls", falls, 0);
      chk("glitch3_rx", rx, 1'b1);
      // 4-cycle low pulse accepted five edges after first low sample
      first = -1; falls = 0;
      for (int k = 0; k < 12; k++) begin
         ext_low = (k < 4);
         cycle();
         if (rx_fall) falls++;
         if (rx == 1'b0 && first < 0) first = k;
      end
      ext_low = 0;
      chk_int("glitch4_fall_edge", first, 5);
      chk_int("glitch4_falls", falls, 1);

      // push-pull toggling with loopback
      do_reset();
      filt_len = '0; mode_pp = 1; drive_low = 0; pull_en = 1;
      for (int t = 0; t < 40; t++) begin
         if (t > 0 && t % 8 == 0) drive_low = ~drive_low;
         cycle();
         chk("pp_oen", pad_oen, 1'b0);
         chk("pp_i", pad_i, ~drive_low);
      end
      chk("pp_no_cont", contention, 1'b0);

      // en dropped in CHK on the same edge as a detect with clear requested
      drive_low = 1;
      for (int t = 0; t < 6; t++) cycle();
      chk("en_pen_before", pad_pen, 1'b0);
      ext_high = 1;
      cycle();
      cycle();
      en = 0; clr = 1;
      cycle();
      chk("en_off_oen", pad_oen, 1'b1);
      chk("en_off_pen", pad_pen, 1'b1);
      chk("en_set_wins", contention, 1'b1);
      clr = 0; ext_high = 0; en = 1;
      cycle();

      // randomized operation
      hold = 0;
      for (int n = 0; n < 4000; n++) begin
         if (hold == 0) begin
            en        = ($urandom_range(0, 9) != 0);
            mode_pp   = 1'($urandom_range(0, 1));
            drive_low = 1'($urandom_range(0, 1));
            pull_en   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) filt_len = FILT_W'($urandom_range(0, 5));
            hold = $urandom_range(6, 12);
         end
         hold--;
         ext_low  = ($urandom_range(0, 19) == 0);
         ext_high = ($urandom_range(0, 29) == 0);
         clr      = ($urandom_range(0, 15) == 0);
         rst      = ($urandom_range(0, 499) == 0);
         cycle();
      end
      rst = 0; clr = 0; ext_low = 0; ext_high = 0;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
